// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter-FIFO write-side signals shared by uart_tx_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the FIFO.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_din;
  logic                 tx_wr_en;
  logic                 tx_full;

  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, tx_din, tx_wr_en
  );

  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, tx_din, tx_wr_en
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter that shares one UART transmitter FIFO
// between NUM_REQ byte-stream requesters; a grant ends on last byte, MAX_MSG or TIMEOUT.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_MSG = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout_evt,
  output logic               forced_evt
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, XFER} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [15:0]        byte_cnt_q, byte_cnt_d;
  logic [15:0]        idle_cnt_q, idle_cnt_d;
  logic               tout_q, tout_d;
  logic               forced_q, forced_d;

  logic [16:0]        byte_inc;
  logic [16:0]        idle_inc;
  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      cand;

  assign byte_inc = {1'b0, byte_cnt_q} + 17'd1;
  assign idle_inc = {1'b0, idle_cnt_q} + 17'd1;

  // First valid requester strictly after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.tx_wr_en  = 1'b0;
    bus.tx_din    = '0;
    if (state_q == XFER) begin
      bus.req_ready = grant_q & {NUM_REQ{!bus.tx_full}};
      bus.tx_wr_en  = bus.req_valid[gidx_q] & !bus.tx_full;
      bus.tx_din    = bus.req_data[{gidx_q, 3'b000} +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    tout_d     = 1'b0;
    forced_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = XFER;
          grant_d    = NUM_REQ'(1) << win_idx;
          gidx_d     = win_idx;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      XFER: begin
        if (bus.tx_wr_en) begin
          byte_cnt_d = byte_inc[15:0];
          idle_cnt_d = '0;
          if (bus.req_last[gidx_q] || byte_inc == 17'(MAX_MSG)) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = gidx_q;
            forced_d = !bus.req_last[gidx_q];
          end
        end else if (!bus.tx_full) begin
          // Only silence with room in the FIFO counts toward the timeout.
          idle_cnt_d = idle_inc[15:0];
          if (idle_inc == 17'(TIMEOUT)) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = gidx_q;
            tout_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= IW'(NUM_REQ - 1);
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      tout_q     <= 1'b0;
      forced_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      tout_q     <= tout_d;
      forced_q   <= forced_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q == XFER);
  assign timeout_evt = tout_q;
  assign forced_evt  = forced_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NUM_REQ=4, MAX_MSG=4, TIMEOUT=8.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [N-1:0] grant;
  logic       busy, timeout_evt, forced_evt;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_MSG(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .grant(grant),
    .busy(busy), .timeout_evt(timeout_evt), .forced_evt(forced_evt)
  );

  always #5 clk = ~clk;

  // Per-requester pending bytes: bit 8 is the last flag.
  logic [8:0] srcq [N][$];

  // Monitor-owned logs and counters; the main sequence only reads them.
  logic [7:0]   txlog[$];
  logic [N-1:0] grantlog[$];
  logic [N-1:0] prev_grant = '0;
  int wr_full_cnt = 0, rdy_full_cnt = 0, tout_cnt = 0, forced_cnt = 0;

  int checks = 0, errors = 0;
  int tx_base, g_base, wf_base, rf_base, to_base, fo_base;
  logic [7:0]   explog[$];
  logic [N-1:0] expgrant[$];

  always @(posedge clk) begin
    if (bus.tx_wr_en) begin
      txlog.push_back(bus.tx_din);
      if (bus.tx_full) wr_full_cnt++;
    end
    if (|bus.req_ready && bus.tx_full) rdy_full_cnt++;
    if (timeout_evt) tout_cnt++;
    if (forced_evt) forced_cnt++;
    if (grant != '0 && grant != prev_grant) grantlog.push_back(grant);
    prev_grant = grant;
  end

  // Requester model: present queue heads, pop on accepted handshakes.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < N; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) void'(srcq[i].pop_front());
      #1;
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() > 0) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_data[8*i +: 8] = srcq[i][0][7:0];
          bus.req_last[i]        = srcq[i][0][8];
        end else begin
          bus.req_valid[i]       = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]        = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    tx_base = txlog.size();
    g_base  = grantlog.size();
    wf_base = wr_full_cnt;
    rf_base = rdy_full_cnt;
    to_base = tout_cnt;
    fo_base = forced_cnt;
    explog.delete();
    expgrant.delete();
  endtask

  task automatic flush_src();
    for (int i = 0; i < N; i++) srcq[i].delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.tx_full = 1'b0;
    flush_src();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mark();
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    @(negedge clk);
    while (grant == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grant_seen"}, 32'(grant != '0), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size() != 0
            || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, 32'(n < 300), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 32'(txlog.size() - tx_base), 32'(explog.size()));
    for (int i = 0; i < explog.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i),
          (tx_base + i < txlog.size()) ? 32'(txlog[tx_base + i]) : 32'hFFFF_FFFF,
          32'(explog[i]));
  endtask

  task automatic check_grants(input string tag);
    chk({tag, "_ngrants"}, 32'(grantlog.size() - g_base), 32'(expgrant.size()));
    for (int i = 0; i < expgrant.size(); i++)
      chk($sformatf("%s_grant%0d", tag, i),
          (g_base + i < grantlog.size()) ? 32'(grantlog[g_base + i]) : 32'hFFFF_FFFF,
          32'(expgrant[i]));
  endtask

  initial begin
    bus.tx_full = 1'b0;
    mark();
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tout", 32'(timeout_evt), 32'h0);
    chk("rst_forced", 32'(forced_evt), 32'h0);
    chk("rst_wr_en", 32'(bus.tx_wr_en), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_din", 32'(bus.tx_din), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    mark();

    // r0 and r2, 3-byte messages
    srcq[0] = '{9'h010, 9'h011, 9'h112};
    srcq[2] = '{9'h030, 9'h031, 9'h132};
    @(negedge clk);
    chk("t1_arb_latency", 32'(grant), 32'h0);
    @(negedge clk);
    chk("t1_grant0", 32'(grant), 32'h1);
    chk("t1_din0", 32'(bus.tx_din), 32'h10);
    chk("t1_wr0", 32'(bus.tx_wr_en), 32'h1);
    chk("t1_ready0", 32'(bus.req_ready), 32'h1);
    repeat (3) @(negedge clk);
    chk("t1_gap_grant", 32'(grant), 32'h0);
    chk("t1_gap_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("t1_grant2", 32'(grant), 32'h4);
    chk("t1_din2", 32'(bus.tx_din), 32'h30);
    wait_drain("t1");
    explog = '{8'h10, 8'h11, 8'h12, 8'h30, 8'h31, 8'h32};
    check_log("t1");

    // All four valid, 2-byte messages
    do_reset();
    srcq[0] = '{9'h0A0, 9'h1A1, 9'h0A8, 9'h1A9};
    srcq[1] = '{9'h0B0, 9'h1B1};
    srcq[2] = '{9'h0C0, 9'h1C1};
    srcq[3] = '{9'h0D0, 9'h1D1};
    wait_drain("t2");
    explog   = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hD1, 8'hA8, 8'hA9};
    expgrant = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    check_log("t2");
    check_grants("t2");

    // Timeout after one byte
    do_reset();
    srcq[1] = '{9'h055};
    srcq[3] = '{9'h177};
    wait_grant("t3");
    chk("t3_grant1", 32'(grant), 32'h2);
    @(negedge clk);
    repeat (7) @(negedge clk);
    chk("t3_pre_grant", 32'(grant), 32'h2);
    chk("t3_pre_tout", 32'(timeout_evt), 32'h0);
    @(negedge clk);
    chk("t3_tout_pulse", 32'(timeout_evt), 32'h1);
    chk("t3_tout_grant", 32'(grant), 32'h0);
    @(negedge clk);
    chk("t3_tout_end", 32'(timeout_evt), 32'h0);
    chk("t3_next_grant", 32'(grant), 32'h8);
    wait_drain("t3");
    explog = '{8'h55, 8'h77};
    check_log("t3");
    chk("t3_forced_cnt", 32'(forced_cnt - fo_base), 32'd0);

    // No timeout progress while the FIFO is full
    do_reset();
    srcq[1] = '{9'h066};
    srcq[3] = '{9'h178};
    wait_grant("t3b");
    @(negedge clk);
    bus.tx_full = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3b_full_grant", 32'(grant), 32'h2);
    chk("t3b_full_tout", 32'(tout_cnt - to_base), 32'd0);
    bus.tx_full = 1'b0;
    repeat (7) @(negedge clk);
    chk("t3b_pre_grant", 32'(grant), 32'h2);
    chk("t3b_pre_tout", 32'(timeout_evt), 32'h0);
    @(negedge clk);
    chk("t3b_tout_pulse", 32'(timeout_evt), 32'h1);
    @(negedge clk);
    chk("t3b_next_grant", 32'(grant), 32'h8);
    wait_drain("t3b");
    explog = '{8'h66, 8'h78};
    check_log("t3b");

    // MAX_MSG forced release of a 6-byte stream
    do_reset();
    srcq[0] = '{9'h101};
    srcq[1] = '{9'h020, 9'h021, 9'h022, 9'h023, 9'h024, 9'h125};
    srcq[2] = '{9'h102};
    srcq[3] = '{9'h103};
    wait_drain("t4");
    explog   = '{8'h01, 8'h20, 8'h21, 8'h22, 8'h23, 8'h02, 8'h03, 8'h24, 8'h25};
    expgrant = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h2};
    check_log("t4");
    check_grants("t4");
    chk("t4_forced_cnt", 32'(forced_cnt - fo_base), 32'd1);
    chk("t4_tout_cnt", 32'(tout_cnt - to_base), 32'd0);

    // Last byte coinciding with MAX_MSG is a normal release
    do_reset();
    srcq[2] = '{9'h040, 9'h041, 9'h042, 9'h143};
    wait_drain("t4b");
    explog = '{8'h40, 8'h41, 8'h42, 8'h43};
    check_log("t4b");
    chk("t4b_forced_cnt", 32'(forced_cnt - fo_base), 32'd0);

    // tx_full toggling during a 5-byte message
    do_reset();
    srcq[0] = '{9'h050, 9'h051, 9'h052, 9'h053, 9'h154};
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (srcq[0].size() == 0 && !busy) break;
      bus.tx_full = ~bus.tx_full;
      #1;
      if (grant == 4'h1)
        chk("t5_ready_follows_full", 32'(bus.req_ready), bus.tx_full ? 32'h0 : 32'h1);
    end
    bus.tx_full = 1'b0;
    wait_drain("t5");
    explog = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
    check_log("t5");
    chk("t5_wr_while_full", 32'(wr_full_cnt - wf_base), 32'd0);
    chk("t5_rdy_while_full", 32'(rdy_full_cnt - rf_base), 32'd0);
    chk("t5_forced_cnt", 32'(forced_cnt - fo_base), 32'd1);

    // Reset in the middle of a message
    do_reset();
    srcq[2] = '{9'h060, 9'h061, 9'h162};
    wait_grant("t6");
    chk("t6_grant", 32'(grant), 32'h4);
    @(negedge clk);
    chk("t6_din_b2", 32'(bus.tx_din), 32'h61);
    chk("t6_wr_b2", 32'(bus.tx_wr_en), 32'h1);
    rst_n = 1'b0;
    flush_src();
    #1;
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_wr", 32'(bus.tx_wr_en), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    explog = '{8'h60};
    check_log("t6_partial");
    @(negedge clk);
    mark();
    srcq[2] = '{9'h171};
    srcq[0] = '{9'h170};
    wait_grant("t6b");
    chk("t6_first_after_rst", 32'(grant), 32'h1);
    wait_drain("t6b");
    explog = '{8'h70, 8'h71};
    check_log("t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one serial_transmitter byte FIFO (din/wr_en/full) between NUM_REQ independent byte-stream requesters.
- Arbitration is round-robin at message granularity. A granted requester keeps the transmitter until it sends its last byte, reaches MAX_MSG bytes, or goes silent for TIMEOUT cycles.
- This guarantees that messages from different sources are never interleaved on TX.
- The block sits between debug/status producers and the transmitter's write side.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_MSG, 64: maximum bytes per grant before forced release, 1..65535.
- TIMEOUT, 1023: consecutive cycles with no req_valid from the granted requester before forced release, 1..65535.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a message; qualified by req_valid.
- req_ready  out  NUM_REQ  per-requester accept.
- tx_din  out  8  byte to the transmitter FIFO din.
- tx_wr_en  out  1  write strobe to the transmitter FIFO wr_en.
- tx_full  in  1  transmitter FIFO full.
- grant  out  NUM_REQ  registered one-hot owner; all zero when idle.
- busy  out  1  high while in XFER.
- timeout_evt  out  1  one-cycle pulse when a grant is released by timeout.
- forced_evt  out  1  one-cycle pulse when a grant is released by MAX_MSG.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; grant=0; busy=0; timeout_evt=0; forced_evt=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - byte_cnt=0; idle_cnt=0.
  - Combinational outputs evaluate to tx_wr_en=0, req_ready=0, tx_din=0.
- States: IDLE, XFER.
- IDLE:
  - If any req_valid: choose the first set bit searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - Next cycle: grant=onehot(winner), state=XFER, byte_cnt=0, idle_cnt=0.
  - No byte is accepted in IDLE, so arbitration latency is 1 cycle.
- XFER (g = granted index):
  - req_ready[g] = !tx_full. All other req_ready bits are 0.
  - tx_wr_en = req_valid[g] & !tx_full (combinational).
  - tx_din = req_data[g] when granted; 0 in IDLE.
  - Byte accept (tx_wr_en=1): byte_cnt+1; idle_cnt=0.
  - Release on accept: if req_last[g], or byte_cnt+1==MAX_MSG, then next state=IDLE, grant=0, rr_ptr=g.
    - forced_evt pulses only if the release was by MAX_MSG without req_last.
  - req_valid[g]=0 and !tx_full: idle_cnt+1. When idle_cnt+1==TIMEOUT: release as above and pulse timeout_evt.
  - tx_full=1: hold idle_cnt. Backpressure never counts toward timeout.
- Minimum gap between messages: 1 IDLE cycle, i.e. at most one grant change per 2 cycles.
- Requester valid/data must stay stable while valid and not ready; the arbiter does not buffer.
- Width rules:
  - byte_cnt and idle_cnt are 16 bits.
  - Comparisons use the incremented value, so MAX_MSG=1 gives exactly one byte per grant.
- Simultaneous last byte and MAX_MSG limit: counts as a normal release; forced_evt=0.
- Reset mid-message: grant dropped immediately; the partially sent message is not recovered. Upstream must restart it.
- No byte is ever written while tx_full=1. No byte is ever duplicated or dropped while granted.

Test Plan:
- Reset, then req_valid=4'b0101 with 3-byte messages from requesters 0 and 2 (last on byte 3) → TX FIFO receives r0 bytes 0x10,0x11,0x12 then r2 bytes 0x30,0x31,0x32. grant goes 0001 then 0100, with one idle cycle between.
- All four requesters continuously valid, 2-byte messages → grant order 0,1,2,3,0. No interleaving within a message.
- Granted requester sends 1 byte, then drops valid for TIMEOUT=8 cycles → timeout_evt pulses on cycle 8; next requester granted. Repeat with tx_full held high for 20 cycles first → no timeout during full.
- MAX_MSG=4, requester 1 sends 6 bytes without last → 4 bytes written, forced_evt=1. The remaining 2 bytes are sent under a fresh grant after the other requesters are served.
- tx_full toggled every other cycle during a 5-byte message → req_ready follows !tx_full; exactly 5 writes; none occur while tx_full=1.
- rst_n asserted during the 2nd byte of a message → grant=0 and tx_wr_en=0 immediately. After release, requester 0 wins first.
